fifo_rd_packer: RTL and testbench

Read-side consumer for the team's asynchronous FIFO. It lives entirely in the read clock domain and drives the FIFO read port (rd_en, rdata, empty, underflow). It pops WIDTH-bit entries, packs PACK consecutive entries into one wide word, and presents each word on a valid/ready stream to downstream logic. A flush request emits a partial word; FIFO underflow events are latched as a sticky error.

---
 rtl/fifo_rd_packer.sv | 105 ++++++++++
 tb/tb_fifo_rd_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the async FIFO: pops entries, packs PACK of them per
// output word, and streams words on valid/ready with flush and sticky underflow.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = 16
) (
  input  logic                    rd_clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    empty,
  input  logic                    underflow,
  input  logic [WIDTH-1:0]        rdata,
  output logic                    rd_en,
  output logic [WIDTH*PACK-1:0]   out_data,
  output logic [$clog2(PACK):0]   out_lanes,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_underflow,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int LW = $clog2(PACK) + 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state;
  logic [LW-1:0]         lane_cnt;
  logic                  pend;
  logic                  flush_req;
  logic [WIDTH*PACK-1:0] packer;
  logic [LW:0]           occupancy;
  logic                  handshake;
  logic                  out_free;

  // Lanes already filled plus the pop still in flight must leave room for another.
  assign occupancy = {1'b0, lane_cnt} + {{LW{1'b0}}, pend};
  assign rd_en     = rst_n && enable && !empty && (occupancy < (LW+1)'(PACK)) && (state == FILL);
  assign handshake = out_valid && out_ready;
  assign out_free  = !out_valid || out_ready;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      lane_cnt      <= '0;
      pend          <= 1'b0;
      flush_req     <= 1'b0;
      packer        <= '0;
      out_data      <= '0;
      out_lanes     <= '0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
      err_underflow <= 1'b0;
      word_cnt      <= '0;
    end else begin
      pend          <= rd_en;
      err_underflow <= err_underflow | underflow;

      if (handshake) begin
        word_cnt  <= word_cnt + CNT_W'(1);
        out_valid <= 1'b0;
      end

      // A landing pop is captured in any state, including after enable drops.
      if (pend) begin
        for (int i = 0; i < PACK; i++) begin
          if (lane_cnt == LW'(i)) packer[i*WIDTH +: WIDTH] <= rdata;
        end
        lane_cnt <= lane_cnt + LW'(1);
      end

      case (state)
        FILL: begin
          if (lane_cnt == LW'(PACK)) begin
            state <= FULL;
          end else if (flush_req && !pend) begin
            if (lane_cnt != '0)  state     <= FLUSH;
            else if (!rd_en)     flush_req <= 1'b0;
          end
        end
        FULL, FLUSH: begin
          if (!pend && out_free) begin
            out_data  <= packer;
            out_lanes <= lane_cnt;
            out_last  <= (state == FLUSH);
            out_valid <= 1'b1;
            packer    <= '0;
            lane_cnt  <= '0;
            if (state == FLUSH) flush_req <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase

      // A new request always survives, even in the cycle a previous one retires.
      if (flush) flush_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: an array-based FIFO model feeds the DUT, a monitor
// records accepted words, and each scenario task checks them against expectations.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CNT_W = 4;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        empty;
  logic        underflow = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rd_en;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_underflow;
  logic [3:0]  word_cnt;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .empty(empty), .underflow(underflow), .rdata(rdata), .rd_en(rd_en),
    .out_data(out_data), .out_lanes(out_lanes), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_underflow(err_underflow), .word_cnt(word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int fails  = 0;
  int exp_total = 0;

  // FIFO model: pushes happen on the falling edge, pops on rd_en at the rising edge.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  l;
    logic        last;
  } word_t;
  word_t got[$];

  always @(posedge rd_clk) begin
    if (rst_n && out_valid && out_ready) got.push_back('{d: out_data, l: out_lanes, last: out_last});
  end

  always @(posedge rd_clk) begin
    checks++;
    if (rd_en && empty) begin
      fails++;
      $display("FAIL rd_en_while_empty: rd_en=%b empty=%b at %0t, required never both 1", rd_en, empty, $time);
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge rd_clk);
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) @(negedge rd_clk);
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (word_cnt !== 4'd0) begin fails++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    checks++; if (out_data !== 32'h0 || out_lanes !== 3'd0 || out_last !== 1'b0) begin
      fails++; $display("FAIL reset_out_regs: got %h/%0d/%b want 0/0/0", out_data, out_lanes, out_last);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (rd_en !== 1'b1) begin fails++; $display("FAIL release_rd_en: got %b want 1", rd_en); end
  endtask

  task automatic test_basic_pack();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_en !== 1'b1) begin fails++; $display("FAIL basic_rd_en_%0d: got %b want 1", i, rd_en); end
      @(negedge rd_clk); #1;
    end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL basic_rd_en_stop: got %b want 0", rd_en); end
    wait_words(1, 10, ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d words want 1", got.size()); end
    if (ok) begin
      checks++; if (got[0].d !== 32'h44332211) begin fails++; $display("FAIL basic_data: got %h want 44332211", got[0].d); end
      checks++; if (got[0].l !== 3'd4 || got[0].last !== 1'b0) begin
        fails++; $display("FAIL basic_lanes_last: got %0d/%b want 4/0", got[0].l, got[0].last);
      end
    end
    got.delete();
    exp_total = 1;
    checks++; if (word_cnt !== 4'(exp_total)) begin fails++; $display("FAIL basic_word_cnt: got %0d want %0d", word_cnt, exp_total); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (30) @(negedge rd_clk);
    checks++; if (out_valid !== 1'b1 || out_data !== exp[0]) begin
      fails++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", out_valid, out_data, exp[0]);
    end
    checks++; if (dut.packer !== exp[1]) begin fails++; $display("FAIL bp_packer: got %h want %h", dut.packer, exp[1]); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en: got %b want 0", rd_en); end
    checks++; if (wr_ptr - rd_ptr != 4) begin fails++; $display("FAIL bp_fifo_level: got %0d want 4", wr_ptr - rd_ptr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      checks++; if (out_data !== exp[0] || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_stable_%0d: got %b/%h want 1/%h", i, out_valid, out_data, exp[0]);
      end
    end
    out_ready = 1'b1;
    wait_words(3, 60, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_timeout: got %0d words want 3", got.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i].d !== exp[i] || got[i].l !== 3'd4 || got[i].last !== 1'b0) begin
          fails++; $display("FAIL bp_word_%0d: got %h/%0d/%b want %h/4/0", i, got[i].d, got[i].l, got[i].last, exp[i]);
        end
      end
    end
    got.delete();
    exp_total = exp_total + 3;
    checks++; if (word_cnt !== 4'(exp_total)) begin fails++; $display("FAIL bp_word_cnt: got %0d want %0d", word_cnt, exp_total); end
  endtask

  task automatic test_flush();
    bit ok;
    push(8'hAA); push(8'hBB);
    repeat (8) @(negedge rd_clk);
    checks++; if (got.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_premature: got %0d words valid=%b want 0/0", got.size(), out_valid);
    end
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_words(1, 10, ok);
    checks++; if (!ok) begin fails++; $display("FAIL flush_timeout: got %0d words want 1", got.size()); end
    if (ok) begin
      checks++; if (got[0].d !== 32'h0000BBAA || got[0].l !== 3'd2 || got[0].last !== 1'b1) begin
        fails++; $display("FAIL flush_word: got %h/%0d/%b want 0000bbaa/2/1", got[0].d, got[0].l, got[0].last);
      end
    end
    got.delete();
    exp_total = exp_total + 1;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    repeat (10) @(negedge rd_clk);
    checks++; if (got.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_empty_emitted: got %0d words valid=%b want 0/0", got.size(), out_valid);
    end
    checks++; if (word_cnt !== 4'(exp_total)) begin fails++; $display("FAIL flush_word_cnt: got %0d want %0d", word_cnt, exp_total); end
  endtask

  task automatic test_underflow();
    checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL uf_pre: got %b want 0", err_underflow); end
    underflow = 1'b1;
    @(negedge rd_clk);
    underflow = 1'b0;
    checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    repeat (5) @(negedge rd_clk);
    checks++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    repeat (15) @(negedge rd_clk);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    checks++; if (dut.lane_cnt !== 3'd0) begin fails++; $display("FAIL rmid_lane_cnt: got %0d want 0", dut.lane_cnt); end
    checks++; if (err_underflow !== 1'b0 || word_cnt !== 4'd0) begin
      fails++; $display("FAIL rmid_err_cnt: got %b/%0d want 0/0", err_underflow, word_cnt);
    end
    @(negedge rd_clk);
    rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    wait_words(1, 20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rmid_timeout: got %0d words want 1", got.size()); end
    if (ok) begin
      checks++; if (got[0].d !== 32'h58575655 || got[0].l !== 3'd4 || got[0].last !== 1'b0) begin
        fails++; $display("FAIL rmid_word: got %h/%0d/%b want 58575655/4/0", got[0].d, got[0].l, got[0].last);
      end
    end
    got.delete();
    exp_total = 1;
  endtask

  task automatic test_random_stream();
    logic [7:0] model[$];
    logic [31:0] w;
    int pushed = 0;
    int nwords = 15;
    for (int c = 0; c < 4000; c++) begin
      @(negedge rd_clk);
      if (pushed < nwords * PACK && $urandom_range(0, 3) != 0) begin
        w[7:0] = 8'($urandom);
        push(w[7:0]);
        model.push_back(w[7:0]);
        pushed++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      enable    = ($urandom_range(0, 4) != 0);
      if (got.size() >= nwords) break;
    end
    enable = 1'b1;
    out_ready = 1'b1;
    checks++; if (got.size() != nwords) begin fails++; $display("FAIL rand_count: got %0d words want %0d", got.size(), nwords); end
    for (int k = 0; k < nwords && k < got.size(); k++) begin
      for (int j = 0; j < PACK; j++) w[j*8 +: 8] = model[k*PACK + j];
      checks++; if (got[k].d !== w || got[k].l !== 3'd4 || got[k].last !== 1'b0) begin
        fails++; $display("FAIL rand_word_%0d: got %h/%0d/%b want %h/4/0", k, got[k].d, got[k].l, got[k].last, w);
      end
    end
    exp_total = (exp_total + nwords) % 16;
    @(negedge rd_clk);
    checks++; if (word_cnt !== 4'(exp_total)) begin fails++; $display("FAIL rand_word_cnt_wrap: got %0d want %0d", word_cnt, exp_total); end
    got.delete();
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_flush();
    test_underflow();
    test_reset_mid_word();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
